// File: rtl/pipelined_carry_skip_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_carry_skip_adder_pkg
//   Shared configuration for the pipelined carry-skip adder family.
//   - DEF_* : default geometry (32-bit operands, 4-bit skip groups,
//             2 groups per pipeline stage).
//   - stage_bits() : operand bits resolved per pipeline stage (S).
//   - num_stages() : pipeline depth, which is also the latency in cycles.
//   - width_ok()   : legality of a geometry. WIDTH must split evenly into stages.
//   - S / NSTAGE   : the derived constants for the default geometry.
// -----------------------------------------------------------------------------
package pipelined_carry_skip_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 4;
  localparam int DEF_GPS   = 2;

  function automatic int stage_bits(input int block, input int gps);
    return block * gps;
  endfunction

  function automatic int num_stages(input int width, input int block, input int gps);
    return width / (block * gps);
  endfunction

  function automatic bit width_ok(input int width, input int block, input int gps);
    return (block > 0) && (gps > 0) && (width > 0) && ((width % (block * gps)) == 0);
  endfunction

  localparam int S      = stage_bits(DEF_WIDTH == 0 ? 0 : DEF_BLOCK, DEF_GPS);
  localparam int NSTAGE = num_stages(DEF_WIDTH, DEF_BLOCK, DEF_GPS);

  // Guards the default geometry itself. Each top instance repeats the
  // check for its own parameters.
  localparam bit DEF_GEOMETRY_OK = width_ok(DEF_WIDTH, DEF_BLOCK, DEF_GPS);

endpackage

// File: rtl/carry_skip_group.sv
// -----------------------------------------------------------------------------
// carry_skip_group
//   BLOCK-bit ripple adder with a carry bypass. When every bit of the group
//   propagates (a ^ b all ones), the group carry-out is taken directly from
//   the group carry-in instead of waiting for the ripple chain.
//   The sum bits always come from the ripple chain.
//   Ports:
//     a, b [BLOCK] in  : group operand slices
//     cin          in  : group carry-in
//     sum  [BLOCK] out : group sum
//     cout         out : group carry-out (bypassed when all-propagate)
// -----------------------------------------------------------------------------
module carry_skip_group
  import pipelined_carry_skip_adder_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0]   ripple;
  logic [BLOCK-1:0] prop;
  logic             bypass;

  assign ripple[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ripple[i]),
      .sum  (sum[i]),
      .cout (ripple[i+1])
    );
  end

  assign prop   = a ^ b;
  assign bypass = &prop;
  // The ripple result is logically identical when bypassing. The mux gives
  // the timing path from cin to cout that skips the chain.
  assign cout   = bypass ? cin : ripple[BLOCK];

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell from the datapath library.
//   Ports: a, b, cin (in) -> sum, cout (out).
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_skip_adder
//   Pipelined carry-skip adder/subtractor with a valid/ready stream interface.
//   Each pipeline stage resolves STAGE_BITS = BLOCK*GROUPS_PER_STAGE bits,
//   starting from the LSB. The partial sum, the inter-stage carry and the
//   not-yet-used operand bits travel down the pipe together.
//   Latency is LATENCY = WIDTH/STAGE_BITS cycles. Throughput is 1 beat/cycle.
//   The whole pipe advances or stalls as one unit.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     in_valid / in_ready  : operand handshake (in_ready = ~out_valid | out_ready)
//     A, B [WIDTH]         : operands
//     Cin                  : carry-in (ignored when Sub=1)
//     Sub                  : 0 -> A+B+Cin, 1 -> A-B
//     out_valid / out_ready: result handshake
//     Sum [WIDTH]          : result
//     Cout                 : MSB carry-out (for Sub=1, 1 means no borrow)
//     Overflow             : two's-complement overflow
//     Zero                 : Sum == 0
// -----------------------------------------------------------------------------
module pipelined_carry_skip_adder
  import pipelined_carry_skip_adder_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int BLOCK            = DEF_BLOCK,
  parameter int GROUPS_PER_STAGE = DEF_GPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int STAGE_BITS = stage_bits(BLOCK, GROUPS_PER_STAGE);
  localparam int LATENCY    = num_stages(WIDTH, BLOCK, GROUPS_PER_STAGE);
  localparam bit WIDTH_OK   = width_ok(WIDTH, BLOCK, GROUPS_PER_STAGE);

  if (!WIDTH_OK) begin : g_width_guard
    $error("pipelined_carry_skip_adder: WIDTH must be a positive multiple of BLOCK*GROUPS_PER_STAGE");
  end

  // ---------------------------------------------------------------------------
  // Handshake and operand transform
  // ---------------------------------------------------------------------------
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + 1. Cin is ignored in that mode.
  assign b_eff   = Sub ? ~B : B;
  assign cin_eff = Sub ? 1'b1 : Cin;

  // ---------------------------------------------------------------------------
  // Stage registers. Entry k holds what stage k produced.
  // ---------------------------------------------------------------------------
  logic             valid_q [LATENCY];
  logic             valid_d [LATENCY];
  logic [WIDTH-1:0] sum_q   [LATENCY];
  logic [WIDTH-1:0] sum_d   [LATENCY];
  logic [WIDTH-1:0] a_q     [LATENCY];
  logic [WIDTH-1:0] a_d     [LATENCY];
  logic [WIDTH-1:0] b_q     [LATENCY];
  logic [WIDTH-1:0] b_d     [LATENCY];
  logic             carry_q [LATENCY];
  logic             carry_d [LATENCY];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Combinational result of each stage.
  logic [WIDTH-1:0] stage_sum   [LATENCY];
  logic             stage_carry [LATENCY];
  logic             msb_carry_in;

  // ---------------------------------------------------------------------------
  // Per-stage datapath: GROUPS_PER_STAGE skip groups chained on the carry.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic [WIDTH-1:0]        src_a;
    logic [WIDTH-1:0]        src_b;
    logic [WIDTH-1:0]        src_sum;
    logic                    src_c;
    logic [GROUPS_PER_STAGE:0] chain;
    logic [STAGE_BITS-1:0]   bits;
    logic [WIDTH-1:0]        merged;

    if (k == 0) begin : g_src_in
      assign src_a   = A;
      assign src_b   = b_eff;
      assign src_sum = '0;
      assign src_c   = cin_eff;
    end else begin : g_src_reg
      assign src_a   = a_q[k-1];
      assign src_b   = b_q[k-1];
      assign src_sum = sum_q[k-1];
      assign src_c   = carry_q[k-1];
    end

    assign chain[0] = src_c;

    for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_grp
      carry_skip_group #(
        .BLOCK (BLOCK)
      ) u_grp (
        .a    (src_a[k*STAGE_BITS + g*BLOCK +: BLOCK]),
        .b    (src_b[k*STAGE_BITS + g*BLOCK +: BLOCK]),
        .cin  (chain[g]),
        .sum  (bits[g*BLOCK +: BLOCK]),
        .cout (chain[g+1])
      );
    end

    // Overlay this stage's slice onto the sum bits resolved so far.
    // NOTE: every variable written in always_comb gets a full default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
      merged = src_sum;
      merged[k*STAGE_BITS +: STAGE_BITS] = bits;
    end

    assign stage_sum[k]   = merged;
    assign stage_carry[k] = chain[GROUPS_PER_STAGE];

    if (k == LATENCY - 1) begin : g_msb
      // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
      assign msb_carry_in = merged[WIDTH-1] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d[0] = in_valid & in_ready;
    a_d[0]     = A;
    b_d[0]     = b_eff;
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1];
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      sum_d[k]   = stage_sum[k];
      carry_d[k] = stage_carry[k];
    end
    ovf_d  = msb_carry_in ^ stage_carry[LATENCY-1];
    zero_d = ~|stage_sum[LATENCY-1];
  end

  // ---------------------------------------------------------------------------
  // State registers: the whole pipe shifts together or holds together.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge input regardless of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath stages are reset along with the valid bits so the
      // visible result (Sum and flags) reads zero out of reset.
      for (int k = 0; k < LATENCY; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < LATENCY; k++) begin
        valid_q[k] <= valid_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        carry_q[k] <= carry_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign Sum       = sum_q[LATENCY-1];
  assign Cout      = carry_q[LATENCY-1];
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: doc/pipelined_carry_skip_adder.md
Name: pipelined_carry_skip_adder

Overview:
Parametrised, pipelined carry-skip (carry-bypass) adder/subtractor with a valid/ready stream interface.
- The WIDTH-bit operand is split into BLOCK-bit skip groups. Each group ripples internally and bypasses its carry-in when all propagate bits are 1.
- A register stage is inserted after every GROUPS_PER_STAGE groups.
- Adds subtract mode, signed-overflow and zero flags, and backpressure.
- Sits in the datapath library as the general-purpose wide adder for accumulators and address units.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK*GROUPS_PER_STAGE.
- BLOCK, 4, bits per skip group.
- GROUPS_PER_STAGE, 2, skip groups evaluated per pipeline stage.
- Derived constant: NSTAGE = WIDTH/(BLOCK*GROUPS_PER_STAGE), which is the latency in cycles (4 at defaults).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cin  in  1  carry-in; ignored when Sub=1
- Sub  in  1  0: A+B+Cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- Sum  out  WIDTH  result
- Cout  out  1  carry-out of MSB; for Sub=1, 1 means no borrow
- Overflow  out  1  two's-complement overflow
- Zero  out  1  Sum == 0

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits clear, so out_valid=0. Sum, Cout, Overflow and Zero reset to 0. in_ready is combinational and equals 1 while out_valid=0. A beat presented in the reset cycle is dropped.
- Handshake:
  - advance = ~out_valid | out_ready, and in_ready = advance.
  - The whole pipeline shifts one stage when advance=1, and holds all stage registers (data and valid) when advance=0.
  - A beat is accepted when in_valid & in_ready. Stage-0 valid loads in_valid & in_ready.
  - Outputs are stable while out_valid=1 and out_ready=0.
- Latency: an accepted beat appears at the output exactly NSTAGE cycles later, provided there is no stall. Throughput is 1 beat/cycle. Order is preserved, with no reordering and no drops.
- Datapath per stage k:
  - Bits [k*S +: S] are processed, where S = BLOCK*GROUPS_PER_STAGE. The stage uses the incoming carry from the previous stage register (stage 0 uses Cin_eff).
  - The stage registers the partial Sum bits computed so far and the carry into the next stage.
  - The upper A/B bits not yet processed travel forward unchanged (skewed operands).
- Operand transform: B_eff = Sub ? ~B : B, and Cin_eff = Sub ? 1 : Cin. Both are applied at the input, before stage 0.
- Skip group rule: P = a ^ b; bypass = &P; group carry-out = bypass ? group carry-in : ripple carry-out. The Sum bits always come from the ripple.
- Flags, computed in the final stage:
  - Cout = carry out of bit WIDTH-1.
  - Overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Zero = ~|Sum.
- Boundaries:
  - An all-propagate operand (A ^ B_eff all ones) must take the full skip path and give a correct carry.
  - Simultaneous accept and output (out_ready=1 while full) must sustain 1/cycle.
  - Reset mid-stream discards every in-flight beat; the first output after reset comes from the first beat accepted after reset.
  - in_valid=0 bubbles propagate as invalid stages and never produce out_valid.

Decomposition:
- Shared package/header holds: the derived constant NSTAGE and the stage-width constant S, plus a localparam guard (elaboration error) for a WIDTH that is not a multiple of S.
- Natural sub-module: carry_skip_group, a parametrised BLOCK-bit ripple adder with bypass mux.
  - Ports: a, b, cin, sum, cout.
  - It is instantiated GROUPS_PER_STAGE times per stage through generate loops.
- The existing full_adder cell is reused inside carry_skip_group.

Test Plan:
- Defaults, out_ready=1: beat A=0x0000_0001, B=0x0000_0002, Cin=1, Sub=0 -> 4 cycles later Sum=0x0000_0004, Cout=0, Overflow=0, Zero=0.
- Full-skip path: A=0xFFFF_FFFF, B=0x0000_0000, Cin=1 -> Sum=0x0000_0000, Cout=1, Zero=1, Overflow=0.
- Subtract and signed overflow:
  - A=0x8000_0000, B=0x0000_0001, Sub=1, Cin=0 -> Sum=0x7FFF_FFFF, Cout=1, Overflow=1.
  - A=5, B=7, Sub=1 -> Sum=0xFFFF_FFFE, Cout=0.
- Backpressure: stream 8 beats i+i (i=1..8) with out_ready low for cycles 6-9 -> in_ready low during the stall, outputs held stable, all 8 results 2,4,...,16 delivered in order, none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst on cycle 2 for 1 cycle -> out_valid=0 until a new beat (A=10, B=20) accepted after reset, which emerges 4 cycles later with Sum=30.
- Parameter sweep: WIDTH=16, BLOCK=4, GROUPS_PER_STAGE=1 (latency 4) and WIDTH=64, BLOCK=8, GROUPS_PER_STAGE=2 (latency 4), each with 10k random beats and random stalls -> every result matches the reference model A+B_eff+Cin_eff, including Cout, Overflow and Zero.
